// File: rtl/fetch_stage_buffered_pkg.sv
// Shared types and helpers for the buffered fetch stage.
// Default widths, default reset PC, and an index-width helper.
package fetch_stage_buffered_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INST_W_DEF = 8;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetch entries: head data is read combinationally, 0-cycle read latency.
// Flush or reset empties it; flush wins over push; the caller must not push when full or pop when empty.
module fetch_fifo
  import fetch_stage_buffered_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush && !reset) slots[wr_ptr] <= push_dat;
  end

  assign head_dat = slots[rd_ptr];

endmodule

// File: rtl/fetch_stage_buffered.sv
// Instruction fetch: PC, 1-cycle synchronous imem, fetch buffer with valid/ready to decode.
// Fetch latency 2 cycles; issue stalls when buffer plus in-flight read would exceed BUF_DEPTH.
module fetch_stage_buffered
  import fetch_stage_buffered_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH = 256,
  parameter int BUF_DEPTH = 2,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [INST_W-1:0] imem_wdata
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int CNT_W = clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_q;
  logic [INST_W-1:0] rd_q;
  logic [INST_W-1:0] imem [DEPTH];
  logic [CNT_W-1:0]  fifo_count;
  entry_t            head;
  entry_t            push_entry;
  logic              has_data;
  logic              pop;
  logic              issue;

  assign has_data = !reset && (fifo_count != '0);
  assign pop      = has_data && inst_ready;
  // Slots already owed: buffered entries plus the read in flight, minus what leaves now.
  assign issue    = !reset && !redirect_valid &&
                    ((int'(fifo_count) + int'(req_q) - int'(pop)) < BUF_DEPTH);

  always_comb begin
    pc_next = pc_q;
    if (reset)               pc_next = RESET_PC_V;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (issue)          pc_next = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_PC_V;
      req_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      req_q <= issue;
    end
    if (issue) req_pc_q <= pc_q;
  end

  // Read-before-write: a same-cycle write to the issued address returns the old word.
  always_ff @(posedge clock) begin
    if (imem_we) imem[imem_waddr[IDX_W-1:0]] <= imem_wdata;
    if (issue)   rd_q <= imem[pc_q[IDX_W-1:0]];
  end

  generate
    if (IDX_W < ADDR_W) begin : g_waddr_hi
      logic unused_waddr_hi;
      assign unused_waddr_hi = ^imem_waddr[ADDR_W-1:IDX_W];
    end
  endgenerate

  assign push_entry = '{pc: req_pc_q, inst: rd_q};

  fetch_fifo #(
    .WIDTH(ADDR_W + INST_W),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (req_q),
    .push_dat(push_entry),
    .pop     (pop),
    .count   (fifo_count),
    .head_dat(head)
  );

  assign inst_valid = has_data;
  assign inst       = has_data ? head.inst : '0;
  assign inst_pc    = has_data ? head.pc : '0;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (int'(fifo_count) + int'(req_q)) <= BUF_DEPTH);

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Directed and random stimulus against a queue-based reference of the fetch stage.
module tb_fetch_stage_buffered;

  localparam int BD = 2;
  localparam logic [7:0] RST_PC = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       inst_ready = 1'b0;
  logic       inst_valid;
  logic [7:0] inst;
  logic [7:0] inst_pc;
  logic [7:0] pc_next;
  logic       imem_we = 1'b0;
  logic [7:0] imem_waddr = '0;
  logic [7:0] imem_wdata = '0;

  always #5 clk = ~clk;

  fetch_stage_buffered #(
    .ADDR_W(8), .INST_W(8), .DEPTH(256), .BUF_DEPTH(BD), .RESET_PC(0)
  ) u_dut (
    .clock(clk), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_ready(inst_ready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .pc_next(pc_next), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
  );

  // Reference: program-order stream of {pc, inst} with at most BD entries owed to decode.
  logic [7:0]  m_pc;
  logic        m_inf;
  logic [15:0] m_inf_e;
  logic [15:0] m_q[$];
  logic [15:0] log_q[$];
  logic [7:0]  mem_m [256];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [7:0] rpc,
                      input logic rdy, input logic we, input logic [7:0] wa,
                      input logic [7:0] wd);
    logic ev, p, iss;
    logic [7:0] ei, ep, en;
    @(negedge clk);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    #1;
    ev  = !rst && (m_q.size() > 0);
    ei  = ev ? m_q[0][7:0] : 8'h00;
    ep  = ev ? m_q[0][15:8] : 8'h00;
    p   = ev && rdy;
    iss = !rst && !rv && ((m_q.size() + int'(m_inf) - int'(p)) < BD);
    en  = rst ? RST_PC : rv ? rpc : iss ? m_pc + 8'd1 : m_pc;
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
    chk("inst", {24'b0, inst}, {24'b0, ei});
    chk("inst_pc", {24'b0, inst_pc}, {24'b0, ep});
    chk("pc_next", {24'b0, pc_next}, {24'b0, en});
    if (p) log_q.push_back(m_q[0]);
    if (rst || rv) begin
      m_q.delete();
      m_inf = 1'b0;
    end else begin
      if (p) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_e);
      m_inf = iss;
      if (iss) m_inf_e = {m_pc, mem_m[m_pc]};
    end
    m_pc = en;
    if (we) mem_m[wa] = wd;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [15:0] e;
    logic [7:0] old05, wd;
    int base;
    m_pc = RST_PC; m_inf = 1'b0; m_inf_e = '0;

    // Program load during reset; 00h..03h = A0h..A3h.
    for (int a = 0; a < 256; a++) begin
      wd = (a < 4) ? 8'hA0 + 8'(a) : 8'($urandom);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'(a), wd);
    end

    log_q.delete();
    run(6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e = (log_q.size() > i) ? log_q[i] : 16'hxxxx;
      chk("first_seq", {16'b0, e}, {16'b0, 8'(i), 8'hA0 + 8'(i)});
    end

    // Back-pressure: stall from cycle 2, then drain in order.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    log_q.delete();
    run(2, 1'b1);
    run(5, 1'b0);
    run(8, 1'b1);
    for (int i = 0; i < 7; i++) begin
      e = (log_q.size() > i) ? log_q[i] : 16'hxxxx;
      chk("bp_order", {24'b0, e[15:8]}, i);
    end

    // Redirect to 40h in cycle 5 with a pop in the same cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    run(5, 1'b1);
    base = log_q.size();
    step(1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("redir_pop", log_q.size(), base + 1);
    run(4, 1'b1);
    e = (log_q.size() > base + 1) ? log_q[base + 1] : 16'hxxxx;
    chk("redir_target", {16'b0, e}, {16'b0, 8'h40, mem_m[8'h40]});

    // PC wrap FEh -> 01h.
    step(1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 8'h00);
    log_q.delete();
    run(6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e = (log_q.size() > i) ? log_q[i] : 16'hxxxx;
      chk("wrap_pc", {24'b0, e[15:8]}, {24'b0, 8'hFE + 8'(i)});
    end

    // Reset with full buffer.
    run(4, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    run(4, 1'b1);

    // Write to 05h in the cycle 05h is issued.
    old05 = mem_m[5];
    step(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00);
    log_q.delete();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 8'h77);
    run(2, 1'b1);
    e = (log_q.size() > 0) ? log_q[0] : 16'hxxxx;
    chk("wr_old", {16'b0, e}, {16'b0, 8'h05, old05});
    step(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00);
    log_q.delete();
    run(3, 1'b1);
    e = (log_q.size() > 0) ? log_q[0] : 16'hxxxx;
    chk("wr_new", {16'b0, e}, {16'b0, 8'h05, 8'h77});

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), 8'($urandom),
           ($urandom_range(3) != 0), ($urandom_range(7) == 0), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
